add_sub_seq: RTL and testbench
==============================

Name: add_sub_seq

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor; next generation of the team's 4-bit combinational adder/subtractor.
- Processes WIDTH-bit operands CHUNK bits per clock, trading latency for area.
- Uses a start/busy/done handshake and reports carry, signed overflow and zero flags.
- Sits between a controller issuing operations and a register file consuming results.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- CHUNK, 1, bits processed per cycle; WIDTH must be an integer multiple of CHUNK (N = WIDTH/CHUNK chunks).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk
- mode  input  1  0 = A+B, 1 = A-B; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while chunks are being processed
- done  output  1  one-cycle pulse; result and flags valid
- result  output  WIDTH  sum/difference; held until the next accepted start
- cout  output  1  carry out of MSB (subtract: 1 = no borrow, A >= B unsigned)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
- zero  output  1  result == 0

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - State goes to IDLE; chunk counter, carry and operand registers clear.
  - busy, done, result, cout, overflow and zero all go to 0.
  - Any in-flight operation is discarded; no done is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch a into shift register SA.
  - Latch b XOR {WIDTH{mode}} into SB.
  - Set carry = mode.
  - Clear the counter and go to RUN.
- RUN, each edge:
  - Add the low CHUNK bits of SA, SB and carry.
  - Shift the sum chunk into result from the MSB side, so the least significant chunk ends at bit 0 after N chunks.
  - Shift SA and SB right by CHUNK; update carry; increment the counter.
  - busy=1 throughout RUN.
- RUN, last chunk (counter == N-1):
  - Also capture the carry into the MSB.
  - Go to DONE with cout, overflow and zero registered.
- DONE, one cycle:
  - done=1, busy=0.
  - If start=1, accept it as in IDLE and go to RUN (back-to-back operation). Otherwise go to IDLE.
- Latency: done is high in the cycle after the N-th rising edge following the edge that captured start. Default 8 edges; WIDTH=8, CHUNK=4 gives 2 edges.
- start while in RUN is ignored. No queueing, and in-flight operands are unaffected.
- Changes on a, b and mode after the capture edge do not affect the operation.
- result and flags during RUN:
  - result is undefined until done; it holds partial data.
  - cout, overflow and zero hold their previous values until the DONE transition updates them.
- After done, result and flags stay stable until the next accepted start. A new start clears nothing visible until its own done.
- Arithmetic is modulo 2^WIDTH.
- zero reflects the full WIDTH-bit result.
- overflow is defined for the signed interpretation only; cout for the unsigned one.

Test Plan:
- WIDTH=8, CHUNK=1, add 0x7F+0x01 -> done 8 edges after capture; result=0x80, cout=0, overflow=1, zero=0; busy high exactly 8 cycles.
- Add 0xFF+0x01 -> result=0x00, cout=1, overflow=0, zero=1.
- Subtract 0x05-0x05 -> result=0x00, cout=1, overflow=0, zero=1.
- Subtract 0x03-0x05 -> result=0xFE, cout=0, overflow=0, zero=0.
- Pulse start with new operands 3 cycles into RUN -> ignored; original result delivered.
- Assert start during the DONE cycle with 0x10+0x20 -> accepted; next done gives 0x30.
- Assert rst asynchronously (mid-cycle) 4 edges into an operation:
  - All outputs go to 0 immediately; no done.
  - After release, 0x40+0x40 completes with result=0x80, overflow=1.
- WIDTH=8, CHUNK=4, subtract 0x80-0x01 -> done 2 edges after capture; result=0x7F, cout=1, overflow=1.
- WIDTH=16, CHUNK=4, add 0xFFFF+0x0001 -> done after 4 edges; result=0x0000, cout=1, zero=1.

Source files
------------

// File: rtl/add_sub_if.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_if
// Purpose  : Start/busy/done handshake and result bus for add_sub_seq.
// Revision : 1.0  initial release
// ============================================================================
interface add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, cout, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/add_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_seq
// Purpose  : Multi-cycle two's-complement adder/subtractor, CHUNK bits/clock.
// Revision : 1.0  initial release
// ============================================================================
module add_sub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic      clk,
    input  logic      rst,
    add_sub_if.slave  bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_RUN  = 2'd1;
    localparam logic [1:0]       c_DONE = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_res_shift;
    logic             w_carry_msb;

    assign w_sum = {1'b0, sa_q[CHUNK-1:0]} + {1'b0, sb_q[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry_q};

    // Carry into the top bit of the final chunk is recovered from the sum bit.
    assign w_carry_msb = sa_q[CHUNK-1] ^ sb_q[CHUNK-1] ^ w_sum[CHUNK-1];

    generate
        if (CHUNK == WIDTH) begin : g_single_chunk
            assign w_res_shift = w_sum[CHUNK-1:0];
        end else begin : g_multi_chunk
            assign w_res_shift = {w_sum[CHUNK-1:0], result_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            c_IDLE, c_DONE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b ^ {WIDTH{bus.mode}};
                    carry_d = bus.mode;
                    cnt_d   = '0;
                    state_d = c_RUN;
                end else begin
                    state_d = c_IDLE;
                end
            end
            c_RUN: begin
                result_d = w_res_shift;
                sa_d     = sa_q >> CHUNK;
                sb_d     = sb_q >> CHUNK;
                carry_d  = w_sum[CHUNK];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == c_LAST) begin
                    cout_d  = w_sum[CHUNK];
                    ovf_d   = w_carry_msb ^ w_sum[CHUNK];
                    zero_d  = (w_res_shift == '0);
                    state_d = c_DONE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= c_IDLE;
            cnt_q    <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy     = (state_q == c_RUN);
    assign bus.done     = (state_q == c_DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_add_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_sub_seq
// Purpose  : Directed self-checking bench for add_sub_seq in three geometries.
// Revision : 1.0  initial release
// ============================================================================
module tb_add_sub_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   edges;
    int   bcnt;
    int   spurious;

    add_sub_if #(.WIDTH(8))  ia ();
    add_sub_if #(.WIDTH(8))  ib ();
    add_sub_if #(.WIDTH(16)) ic ();

    add_sub_seq #(.WIDTH(8),  .CHUNK(1)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
    add_sub_seq #(.WIDTH(8),  .CHUNK(4)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
    add_sub_seq #(.WIDTH(16), .CHUNK(4)) u_c (.clk(clk), .rst(rst), .bus(ic.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch on DUT A; returns at the falling edge right after the capture edge.
    task automatic start_a(input logic m, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        ia.start = 1'b1; ia.mode = m; ia.a = av; ia.b = bv;
        @(negedge clk);
        ia.start = 1'b0; ia.a = 8'hAA; ia.b = 8'h55; ia.mode = ~m;
    endtask

    task automatic wait_a(output int e, output int bc);
        e = 0; bc = 0;
        while (1) begin
            if (ia.busy) bc++;
            if (ia.done || e >= 100) break;
            @(negedge clk);
            e++;
        end
        chk("wait_a_timeout", (e < 100), 1);
    endtask

    initial begin
        checks = 0; errors = 0; spurious = 0;
        rst = 1'b1;
        ia.start = 0; ia.mode = 0; ia.a = 0; ia.b = 0;
        ib.start = 0; ib.mode = 0; ib.a = 0; ib.b = 0;
        ic.start = 0; ic.mode = 0; ic.a = 0; ic.b = 0;
        #12;
        chk("rst_busy",   ia.busy,     1'b0);
        chk("rst_done",   ia.done,     1'b0);
        chk("rst_result", ia.result,   8'h00);
        chk("rst_flags",  {ia.cout, ia.overflow, ia.zero}, 3'b000);
        @(negedge clk); rst = 1'b0;

        // 0x7F + 0x01
        start_a(1'b0, 8'h7F, 8'h01);
        wait_a(edges, bcnt);
        chk("add7f_edges",  edges,       8);
        chk("add7f_busy",   bcnt,        8);
        chk("add7f_result", ia.result,   8'h80);
        chk("add7f_flags",  {ia.cout, ia.overflow, ia.zero}, 3'b010);
        @(negedge clk);
        chk("add7f_hold",   {ia.done, ia.result}, 9'h080);

        // 0xFF + 0x01, flags held during RUN
        start_a(1'b0, 8'hFF, 8'h01);
        chk("addff_runflags", {ia.busy, ia.cout, ia.overflow, ia.zero}, 4'b1010);
        wait_a(edges, bcnt);
        chk("addff_result", ia.result,   8'h00);
        chk("addff_flags",  {ia.cout, ia.overflow, ia.zero}, 3'b101);

        // 0x05 - 0x05
        start_a(1'b1, 8'h05, 8'h05);
        wait_a(edges, bcnt);
        chk("sub55_result", ia.result,   8'h00);
        chk("sub55_flags",  {ia.cout, ia.overflow, ia.zero}, 3'b101);

        // 0x03 - 0x05
        start_a(1'b1, 8'h03, 8'h05);
        wait_a(edges, bcnt);
        chk("sub35_result", ia.result,   8'hFE);
        chk("sub35_flags",  {ia.cout, ia.overflow, ia.zero}, 3'b000);

        // Start pulsed 3 cycles into RUN is ignored
        start_a(1'b0, 8'h11, 8'h22);
        repeat (2) @(negedge clk);
        ia.start = 1'b1; ia.mode = 1'b1; ia.a = 8'h01; ia.b = 8'h01;
        @(negedge clk);
        ia.start = 1'b0;
        wait_a(edges, bcnt);
        chk("ign_done",     ia.done,     1'b1);
        chk("ign_result",   ia.result,   8'h33);
        chk("ign_flags",    {ia.cout, ia.overflow, ia.zero}, 3'b000);

        // Back-to-back start during DONE
        ia.start = 1'b1; ia.mode = 1'b0; ia.a = 8'h10; ia.b = 8'h20;
        @(negedge clk);
        ia.start = 1'b0;
        chk("b2b_busy",     {ia.busy, ia.done}, 2'b10);
        wait_a(edges, bcnt);
        chk("b2b_edges",    edges,       8);
        chk("b2b_result",   ia.result,   8'h30);

        // Asynchronous reset 4 edges into an operation
        start_a(1'b0, 8'hF0, 8'h0F);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ctrl",    {ia.busy, ia.done}, 2'b00);
        chk("arst_result",  ia.result,   8'h00);
        chk("arst_flags",   {ia.cout, ia.overflow, ia.zero}, 3'b000);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ia.done || ia.busy) spurious++;
        end
        chk("arst_nodone",  spurious,    0);
        start_a(1'b0, 8'h40, 8'h40);
        wait_a(edges, bcnt);
        chk("add40_result", ia.result,   8'h80);
        chk("add40_flags",  {ia.cout, ia.overflow, ia.zero}, 3'b010);

        // WIDTH=8, CHUNK=4: 0x80 - 0x01
        @(negedge clk);
        ib.start = 1'b1; ib.mode = 1'b1; ib.a = 8'h80; ib.b = 8'h01;
        @(negedge clk);
        ib.start = 1'b0;
        edges = 0;
        while (!ib.done && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        chk("c4sub_timeout", (edges < 100), 1);
        chk("c4sub_edges",  edges,       2);
        chk("c4sub_result", ib.result,   8'h7F);
        chk("c4sub_flags",  {ib.cout, ib.overflow, ib.zero}, 3'b110);

        // WIDTH=16, CHUNK=4: 0xFFFF + 0x0001
        @(negedge clk);
        ic.start = 1'b1; ic.mode = 1'b0; ic.a = 16'hFFFF; ic.b = 16'h0001;
        @(negedge clk);
        ic.start = 1'b0;
        edges = 0;
        while (!ic.done && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        chk("w16_timeout",  (edges < 100), 1);
        chk("w16_edges",    edges,       4);
        chk("w16_result",   ic.result,   16'h0000);
        chk("w16_flags",    {ic.cout, ic.overflow, ic.zero}, 3'b101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
